// File: rtl/exp_stream_pkg.sv
// ---------------------------------------------------------------------------
// exp_stream_pkg
// Shared definitions for the exponential-pipeline stream source and the
// matching stream sink/checker that will reuse them.
//   Q2_14_WIDTH  : operand width fed into the pipeline
//   Q7_25_WIDTH  : result width produced by the pipeline
//   LFSR_MASK    : Galois tap mask for x^32 + x^22 + x^2 + x + 1
//   stream_state_t : source sequencing states
//   lfsr_next()  : one right-shift Galois step
// ---------------------------------------------------------------------------
package exp_stream_pkg;

   localparam int Q2_14_WIDTH = 16;
   localparam int Q7_25_WIDTH = 32;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } stream_state_t;

   // The bit shifted out selects whether the tap mask is folded back in.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      lfsr_next = (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// ---------------------------------------------------------------------------
// lfsr32_galois
// 32-bit right-shifting Galois LFSR used as the operand generator.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high; loads seed
//   load    : synchronous load of seed (wins over advance)
//   seed    : value loaded on reset/load
//   advance : step the register by one LFSR state
//   q       : current LFSR state
// ---------------------------------------------------------------------------
module lfsr32_galois
   import exp_stream_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        advance,
   output logic [31:0] q
);

   always_ff @(posedge clk) begin
      if (reset || load) begin
         q <= seed;
      end else if (advance) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/exp_stream_src.sv
// ---------------------------------------------------------------------------
// exp_stream_src
// Hardware stream source for the exponential pipeline: emits a deterministic
// pseudo-random Q2.14 operand sequence over a valid/ready handshake, inserts
// one idle gap mid-run to exercise the valid-stall path, and flags completion.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high
//   i_start : one-cycle pulse, starts a run from IDLE or DONE
//   i_ready : downstream ready (pipeline o_ready)
//   o_valid : o_x holds a valid operand
//   o_x     : operand, Q2.14
//   o_busy  : run in progress (SEND or GAP)
//   o_done  : run finished
//   o_count : operands accepted so far in the current run
// ---------------------------------------------------------------------------
module exp_stream_src
   import exp_stream_pkg::*;
#(
   parameter int          WIDTHOUT   = Q2_14_WIDTH,
   parameter int          N_INPUTS   = 50,
   parameter logic [31:0] SEED       = 32'd2,
   parameter int          GAP_AT     = N_INPUTS / 2,
   parameter int          GAP_CYCLES = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic                i_ready,
   output logic                o_valid,
   output logic [WIDTHOUT-1:0] o_x,
   output logic                o_busy,
   output logic                o_done,
   output logic [15:0]         o_count
);

   localparam logic [WIDTHOUT-1:0] FIRST_X  = SEED[WIDTHOUT-1:0];
   localparam logic [15:0]         N_LAST   = 16'(N_INPUTS);
   localparam logic [15:0]         GAP_MARK = 16'(GAP_AT);
   localparam logic [15:0]         GAP_LEN  = 16'(GAP_CYCLES);
   localparam bit                  GAP_EN   = (GAP_AT > 0) && (GAP_AT < N_INPUTS);

   stream_state_t       state, state_nxt;
   logic                valid_nxt, busy_nxt, done_nxt;
   logic [WIDTHOUT-1:0] x_nxt, x_after;
   logic [15:0]         count_nxt, count_inc;
   logic [15:0]         gap_cnt, gap_cnt_nxt;
   logic                lfsr_load, lfsr_adv;
   logic [31:0]         lfsr_q;
   logic                transfer;

   lfsr32_galois u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (lfsr_load),
      .seed    (SEED),
      .advance (lfsr_adv),
      .q       (lfsr_q)
   );

   assign transfer  = o_valid && i_ready;
   assign count_inc = o_count + 16'd1;

   // o_x is its own register (it must read 0 out of reset while the LFSR
   // holds SEED), so on each transfer it is loaded with the operand the LFSR
   // will hold after that same edge.
   assign x_after = WIDTHOUT'(lfsr_next(lfsr_q));

   // Next-state and next-output logic. Registers hold by default, which is
   // what keeps o_x/o_valid stable while the consumer stalls us.
   always_comb begin
      state_nxt   = state;
      valid_nxt   = o_valid;
      x_nxt       = o_x;
      busy_nxt    = o_busy;
      done_nxt    = o_done;
      count_nxt   = o_count;
      gap_cnt_nxt = gap_cnt;
      lfsr_load   = 1'b0;
      lfsr_adv    = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            if (i_start) begin
               state_nxt = SEND;
               lfsr_load = 1'b1;
               count_nxt = 16'd0;
               valid_nxt = 1'b1;
               x_nxt     = FIRST_X;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
            end
         end
         SEND: begin
            if (transfer) begin
               lfsr_adv  = 1'b1;
               count_nxt = count_inc;
               x_nxt     = x_after;
               // Completion takes precedence over the gap point.
               if (count_inc == N_LAST) begin
                  state_nxt = DONE;
                  valid_nxt = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else if (GAP_EN && (count_inc == GAP_MARK)) begin
                  state_nxt   = GAP;
                  valid_nxt   = 1'b0;
                  gap_cnt_nxt = GAP_LEN;
               end
            end
         end
         GAP: begin
            // Leaving on the last gap cycle makes o_valid low for exactly
            // GAP_CYCLES cycles; o_x already holds the next operand.
            if (gap_cnt == 16'd1) begin
               state_nxt = SEND;
               valid_nxt = 1'b1;
            end else begin
               gap_cnt_nxt = gap_cnt - 16'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any run immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         o_valid <= 1'b0;
         o_x     <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_count <= 16'd0;
         gap_cnt <= 16'd0;
      end else begin
         state   <= state_nxt;
         o_valid <= valid_nxt;
         o_x     <= x_nxt;
         o_busy  <= busy_nxt;
         o_done  <= done_nxt;
         o_count <= count_nxt;
         gap_cnt <= gap_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_exp_stream_src.sv
// ---------------------------------------------------------------------------
// tb_exp_stream_src
// Self-checking bench for exp_stream_src with default parameters. Expected
// operands come from a plain arithmetic LFSR model; each scenario task does
// its own comparisons.
// ---------------------------------------------------------------------------
module tb_exp_stream_src;

   localparam int N    = 50;
   localparam int GAPA = 25;
   localparam int GAPC = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_start;
   logic        i_ready;
   logic        o_valid;
   logic [15:0] o_x;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_count;

   int checks = 0;
   int fails  = 0;

   logic [15:0] exp_x [N];

   always #5 clk = ~clk;

   exp_stream_src dut (
      .clk     (clk),
      .reset   (reset),
      .i_start (i_start),
      .i_ready (i_ready),
      .o_valid (o_valid),
      .o_x     (o_x),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_count (o_count)
   );

   // Outputs are observed and inputs changed 1 time unit after each edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference operand list: x^32+x^22+x^2+x+1, right-shifting Galois form,
   // first operand is the low half of the seed.
   task automatic build_model();
      logic [31:0] s;
      s = 32'd2;
      for (int i = 0; i < N; i++) begin
         exp_x[i] = s[15:0];
         if (s[0]) s = (s >> 1) ^ 32'h8020_0003;
         else      s = s >> 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; i_start = 1'b0; i_ready = 1'b0;
      tick(); tick();
      checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", o_valid); end
      checks++; if (o_x !== 16'h0000) begin fails++; $display("[TB] FAIL reset_x: got %h want 0000", o_x); end
      checks++; if (o_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b want 0", o_done); end
      checks++; if (o_count !== 16'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d want 0", o_count); end
      reset = 1'b0;
      tick();
      checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_valid: got %b want 0", o_valid); end
   endtask

   task automatic test_start_sequence();
      i_ready = 1'b1; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL start_latency: valid %b want 1", o_valid); end
      checks++; if (o_busy !== 1'b1) begin fails++; $display("[TB] FAIL start_busy: got %b want 1", o_busy); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (o_valid !== 1'b1 || o_x !== exp_x[k] || o_count !== 16'(k)) begin
            fails++;
            $display("[TB] FAIL seq_%0d: valid %b x %h count %0d want 1 %h %0d", k, o_valid, o_x, o_count, exp_x[k], k);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      i_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_x !== exp_x[6] || o_count !== 16'd6) begin
            fails++;
            $display("[TB] FAIL stall_%0d: valid %b x %h count %0d want 1 %h 6", c, o_valid, o_x, o_count, exp_x[6]);
         end
      end
      i_ready = 1'b1;
   endtask

   // Continues the run started above with ready held high: checks every
   // accepted operand, the idle run before each valid, and the final state.
   task automatic test_gap_and_done();
      int mc = 6;
      int idle = 0;
      int cyc = 0;
      while (o_done !== 1'b1 && cyc < 200) begin
         if (o_valid === 1'b1) begin
            checks++;
            if (mc >= N || o_x !== exp_x[mc] || o_count !== 16'(mc)) begin
               fails++;
               $display("[TB] FAIL gap_seq_%0d: x %h count %0d", mc, o_x, o_count);
            end
            checks++;
            if (idle !== ((mc == GAPA) ? GAPC : 0)) begin
               fails++;
               $display("[TB] FAIL gap_len_%0d: idle cycles %0d want %0d", mc, idle, (mc == GAPA) ? GAPC : 0);
            end
            idle = 0;
            mc++;
         end else begin
            idle++;
         end
         tick();
         cyc++;
      end
      checks++; if (cyc >= 200) begin fails++; $display("[TB] FAIL gap_timeout: done never rose"); end
      checks++; if (mc !== N) begin fails++; $display("[TB] FAIL gap_transfers: got %0d want %0d", mc, N); end
      checks++; if (o_count !== 16'(N) || o_valid !== 1'b0 || o_busy !== 1'b0) begin
         fails++; $display("[TB] FAIL done_state: count %0d valid %b busy %b want %0d 0 0", o_count, o_valid, o_busy, N);
      end
      tick(); tick();
      checks++; if (o_done !== 1'b1 || o_count !== 16'(N)) begin
         fails++; $display("[TB] FAIL done_hold: done %b count %0d want 1 %0d", o_done, o_count, N);
      end
   endtask

   // Restart from DONE, then a full run with random ready.
   task automatic test_random_ready();
      int mc = 0;
      int cyc = 0;
      bit stalled = 1'b0;
      logic [15:0] held_x = '0;
      i_ready = 1'b0; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++; if (o_done !== 1'b0 || o_valid !== 1'b1 || o_x !== exp_x[0] || o_count !== 16'd0) begin
         fails++; $display("[TB] FAIL restart: done %b valid %b x %h count %0d want 0 1 %h 0", o_done, o_valid, o_x, o_count, exp_x[0]);
      end
      while (o_done !== 1'b1 && cyc < 1000) begin
         if (stalled) begin
            checks++;
            if (o_valid !== 1'b1 || o_x !== held_x) begin
               fails++; $display("[TB] FAIL rand_hold: valid %b x %h want 1 %h", o_valid, o_x, held_x);
            end
         end
         if (o_valid === 1'b1) begin
            checks++;
            if (mc >= N || o_x !== exp_x[mc] || o_count !== 16'(mc)) begin
               fails++; $display("[TB] FAIL rand_seq_%0d: x %h count %0d", mc, o_x, o_count);
            end
         end
         i_ready = 1'($urandom_range(0, 1));
         stalled = (o_valid === 1'b1) && !i_ready;
         held_x = o_x;
         if (o_valid === 1'b1 && i_ready) mc++;
         tick();
         cyc++;
      end
      i_ready = 1'b1;
      checks++; if (cyc >= 1000) begin fails++; $display("[TB] FAIL rand_timeout: done never rose"); end
      checks++; if (mc !== N || o_count !== 16'(N)) begin
         fails++; $display("[TB] FAIL rand_transfers: model %0d count %0d want %0d", mc, o_count, N);
      end
   endtask

   // Abort at count 10 with start asserted alongside reset; then replay.
   task automatic test_reset_midrun();
      int cyc = 0;
      i_ready = 1'b1; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      while (o_count !== 16'd10 && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++; if (o_count !== 16'd10) begin fails++; $display("[TB] FAIL mid_reach: count %0d want 10", o_count); end
      reset = 1'b1; i_start = 1'b1;
      tick();
      reset = 1'b0; i_start = 1'b0;
      checks++; if (o_valid !== 1'b0 || o_count !== 16'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         fails++; $display("[TB] FAIL mid_abort: valid %b count %0d busy %b done %b want 0 0 0 0", o_valid, o_count, o_busy, o_done);
      end
      tick();
      checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_wins: valid %b busy %b want 0 0", o_valid, o_busy);
      end
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++; if (o_valid !== 1'b1 || o_x !== exp_x[0]) begin
         fails++; $display("[TB] FAIL mid_replay: valid %b x %h want 1 %h", o_valid, o_x, exp_x[0]);
      end
   endtask

   // Start pulses during SEND and GAP must not disturb the run in progress.
   task automatic test_start_ignored();
      int mc = 0;
      int cyc = 0;
      i_ready = 1'b1;
      while (o_done !== 1'b1 && cyc < 200) begin
         if (o_valid === 1'b1) begin
            checks++;
            if (mc >= N || o_x !== exp_x[mc] || o_count !== 16'(mc)) begin
               fails++; $display("[TB] FAIL ign_seq_%0d: x %h count %0d", mc, o_x, o_count);
            end
            mc++;
         end
         i_start = (cyc % 3 == 0);
         tick();
         cyc++;
      end
      i_start = 1'b0;
      checks++; if (mc !== N || o_count !== 16'(N) || o_done !== 1'b1) begin
         fails++; $display("[TB] FAIL ign_end: model %0d count %0d done %b want %0d %0d 1", mc, o_count, o_done, N, N);
      end
   endtask

   initial begin
      build_model();
      test_reset();
      test_start_sequence();
      test_stall();
      test_gap_and_done();
      test_random_ready();
      test_reset_midrun();
      test_start_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/exp_stream_src.md
Name: exp_stream_src

Overview:
- Synthesizable stream source that generates Q2.14 operands for the exponential pipeline on hardware, where no simulator-side producer exists.
- Drives the pipeline's input-side valid/ready handshake: its o_valid/o_x feed the pipeline's i_valid/i_x, and the pipeline's o_ready feeds its i_ready.
- Produces a deterministic pseudo-random operand sequence, inserts one idle gap mid-run to exercise the valid-stall path, and flags completion.

Parameters:
- WIDTHOUT, 16, operand width (Q2.14).
- N_INPUTS, 50, number of operands per run (1..65535).
- SEED, 32'd2, LFSR load value; first operand = SEED[WIDTHOUT-1:0].
- GAP_AT, N_INPUTS/2, accepted-operand count after which the idle gap is inserted; no gap when GAP_AT >= N_INPUTS or GAP_AT == 0.
- GAP_CYCLES, 3, idle-gap length in cycles (>=1).

Ports:
- clk, input, 1, single clock, all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- i_start, input, 1, one-cycle pulse; starts a run from IDLE or DONE.
- i_ready, input, 1, downstream ready (pipeline o_ready).
- o_valid, output, 1, o_x holds a valid operand.
- o_x, output, WIDTHOUT, operand, Q2.14.
- o_busy, output, 1, high in SEND or GAP.
- o_done, output, 1, high in DONE.
- o_count, output, 16, operands accepted so far in the current run.

Behaviour:
- All outputs registered. Reset (synchronous, active-high): state=IDLE, o_valid=0, o_x=0, o_busy=0, o_done=0, o_count=0, lfsr=SEED. Reset asserted mid-run aborts the run at the next edge with no partial completion.
- Transfer: occurs on a rising edge where o_valid && i_ready.
- While o_valid && !i_ready: o_x and o_valid must hold stable. o_valid never deasserts without a transfer.
- LFSR: 32-bit Galois, right shift, MASK=32'h80200003 (x^32+x^22+x^2+x+1). Next state = (s>>1) ^ (s[0] ? MASK : 0). Advances only on a transfer. o_x = lfsr[WIDTHOUT-1:0] of the current state.
- FSM:
  - IDLE: i_start -> SEND, lfsr=SEED, o_count=0, o_valid=1 on the next cycle (1-cycle start latency).
  - SEND: on a transfer, o_count+1 and LFSR advances.
    - If the new count == N_INPUTS -> DONE, o_valid=0.
    - Else if the new count == GAP_AT -> GAP, o_valid=0, gap counter=GAP_CYCLES.
    - Else stay in SEND; a back-to-back transfer every cycle is allowed (full throughput).
  - GAP: o_valid=0 for exactly GAP_CYCLES cycles, then -> SEND with o_valid=1 holding the next operand.
  - DONE: o_done=1, o_count held. i_start -> SEND, restarting as from IDLE.
- i_start is ignored in SEND and GAP.
- Simultaneous reset and i_start: reset wins.
- o_count does not wrap; N_INPUTS is bounded to 65535.

Decomposition:
- Shared package exp_stream_pkg:
  - Q2.14 width constant (16) and Q7.25 width constant (32).
  - LFSR_MASK=32'h80200003.
  - State enum {IDLE, SEND, GAP, DONE}.
  - The package is reused by a future matching stream sink/checker.
- One sub-module: lfsr32_galois, with ports clk, reset, load, seed, advance, q[31:0]; synchronous load takes priority over advance.
- Top-level: FSM, counters, output registers.

Test Plan:
- Reset then i_start with i_ready=1 held high: o_valid rises one cycle after i_start. Accepted o_x sequence begins 0x0002, 0x0001, 0x0003, 0x0002, one per cycle.
- i_ready=0 for 6 cycles while o_valid=1 at count 6: o_x stays constant and o_count stays 6 throughout. The same value transfers when i_ready returns to 1, and the sequence continues without skipping.
- Defaults, i_ready=1: after the 25th transfer o_valid=0 for exactly 3 cycles, then resumes with the 26th LFSR value. o_done=1 after the 50th transfer, o_count=50, o_valid=0.
- Randomized i_ready (50% duty) over a full run: exactly 50 transfers. The accepted sequence matches the reference LFSR model, and no o_x/o_valid change occurs while stalled.
- Reset asserted at count 10 mid-run: next cycle state=IDLE, o_valid=0, o_count=0. A new i_start replays from 0x0002.
- i_start while in SEND is ignored (count continues). i_start in DONE restarts: o_done drops, first operand is 0x0002.
